// File: rtl/dc_full_detector_mc.sv
// dc_full_detector_mc
//   Write-side full / almost-full detector for a group of dual-clock FIFO
//   channels. Each channel compares its one-hot read pointer, which comes
//   from the read clock domain, with its local one-hot write pointer. Only
//   the resulting single-bit flags are synchronised into the write clock
//   domain. The detector also flags writes attempted while full, and write
//   pointers that are not one-hot.
//
// Ports
//   clk            write-domain clock
//   rst            asynchronous reset, active-high
//   read_pointer   NUM_CHANNELS x BUFFER_DEPTH one-hot read pointers (read domain)
//   write_pointer  NUM_CHANNELS x BUFFER_DEPTH one-hot write pointers (local)
//   valid          per-channel write attempt
//   clear_errors   synchronous clear of the sticky error flags
//   full           per-channel: do not accept writes
//   almost_full    per-channel: within AFULL_SLACK of full
//   overflow       per-channel sticky: write attempted while full
//   pointer_error  per-channel sticky: write pointer not one-hot
module dc_full_detector_mc #(
  parameter int BUFFER_DEPTH = 8,
  parameter int NUM_CHANNELS = 1,
  parameter int FULL_SLACK   = 3,
  parameter int AFULL_SLACK  = 5,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS*BUFFER_DEPTH-1:0] read_pointer,
  input  logic [NUM_CHANNELS*BUFFER_DEPTH-1:0] write_pointer,
  input  logic [NUM_CHANNELS-1:0]              valid,
  input  logic                                 clear_errors,
  output logic [NUM_CHANNELS-1:0]              full,
  output logic [NUM_CHANNELS-1:0]              almost_full,
  output logic [NUM_CHANNELS-1:0]              overflow,
  output logic [NUM_CHANNELS-1:0]              pointer_error
);

  localparam int D = BUFFER_DEPTH;

  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [D-1:0]           rp;
      logic [D-1:0]           wp;
      logic [AFULL_SLACK-1:0] dist_hit;   // dist_hit[k-1]: distance == k
      logic                   full_raw;
      logic                   afull_raw;
      logic [SYNC_STAGES-1:0] full_sync_reg;
      logic [SYNC_STAGES-1:0] afull_sync_reg;
      logic                   full_up;
      logic                   afull_up;
      logic                   latched_reg;
      logic                   full_int;
      logic                   overflow_reg;
      logic                   pointer_error_reg;
      logic                   wp_bad;

      assign rp = read_pointer[gi*D +: D];
      assign wp = write_pointer[gi*D +: D];

      // Distance test: rotate wp left by k (bit i takes wp[(i-k) mod D]) and
      // AND with rp. A hit means rp sits exactly k slots ahead of wp, so the
      // wrap-around case falls out of the rotation.
      for (gk = 1; gk <= AFULL_SLACK; gk++) begin : g_dist
        assign dist_hit[gk-1] = |(rp & {wp[D-1-gk:0], wp[D-1:D-gk]});
      end

      // Raw flags mix both clock domains; they are only ever consumed by
      // the synchroniser chains below.
      assign full_raw  = |dist_hit[FULL_SLACK-1:0];
      assign afull_raw = |dist_hit;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_sync_reg  <= '0;
          afull_sync_reg <= '0;
        end else begin
          full_sync_reg  <= {full_sync_reg[SYNC_STAGES-2:0], full_raw};
          afull_sync_reg <= {afull_sync_reg[SYNC_STAGES-2:0], afull_raw};
        end
      end

      assign full_up  = full_sync_reg[SYNC_STAGES-1];
      assign afull_up = afull_sync_reg[SYNC_STAGES-1];

      // A pending write arms the latch a cycle early, so while valid is held
      // full tracks full_up directly. When idle, full waits one extra cycle.
      // Gating with full_up makes full drop together with full_up.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) latched_reg <= 1'b0;
        else     latched_reg <= full_up | valid[gi];
      end

      assign full_int = latched_reg & full_up;

      // Write pointer must have exactly one bit set. The read pointer is not
      // checked: it is asynchronous and may be caught mid-transition.
      assign wp_bad = (~|wp) | (|(wp & (wp - 1'b1)));

      // Sticky error flags; a new set takes priority over clear_errors.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          overflow_reg      <= 1'b0;
          pointer_error_reg <= 1'b0;
        end else begin
          if (valid[gi] && full_int) overflow_reg <= 1'b1;
          else if (clear_errors)     overflow_reg <= 1'b0;

          if (wp_bad)            pointer_error_reg <= 1'b1;
          else if (clear_errors) pointer_error_reg <= 1'b0;
        end
      end

      assign full[gi]          = full_int;
      assign almost_full[gi]   = afull_up;
      assign overflow[gi]      = overflow_reg;
      assign pointer_error[gi] = pointer_error_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dc_full_detector_mc.sv
module tb_dc_full_detector_mc;

  localparam int D  = 8;
  localparam int NC = 2;

  logic          clk;
  logic          rst;
  logic [NC*D-1:0] read_pointer;
  logic [NC*D-1:0] write_pointer;
  logic [NC-1:0] valid;
  logic          clear_errors;
  logic [NC-1:0] full;
  logic [NC-1:0] almost_full;
  logic [NC-1:0] overflow;
  logic [NC-1:0] pointer_error;

  logic [D-1:0] rp0, rp1, wp0, wp1;

  int tests_run;
  int tests_failed;

  dc_full_detector_mc #(
    .BUFFER_DEPTH(D),
    .NUM_CHANNELS(NC),
    .FULL_SLACK(3),
    .AFULL_SLACK(5),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_pointer(read_pointer),
    .write_pointer(write_pointer),
    .valid(valid),
    .clear_errors(clear_errors),
    .full(full),
    .almost_full(almost_full),
    .overflow(overflow),
    .pointer_error(pointer_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_pointer  = {rp1, rp0};
  assign write_pointer = {wp1, wp0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one active edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    rp0 = 8'h01; rp1 = 8'h01;
    wp0 = 8'h01; wp1 = 8'h01;
    valid = '0;
    clear_errors = 1'b0;

    tick(); tick();
    check("rst_full",  32'(full), 32'h0);
    check("rst_afull", 32'(almost_full), 32'h0);
    check("rst_ovf",   32'(overflow), 32'h0);
    check("rst_perr",  32'(pointer_error), 32'h0);
    rst = 1'b0;

    // 1. d=0 is empty
    repeat (5) tick();
    check("empty_full",  32'(full), 32'h0);
    check("empty_afull", 32'(almost_full), 32'h0);
    check("empty_perr",  32'(pointer_error), 32'h0);

    // 2. d=3, idle: almost_full after 2 edges, full after 3
    rp0 = 8'h08;
    tick();
    check("d3_e1_afull", 32'(almost_full), 32'h0);
    tick();
    check("d3_e2_afull", 32'(almost_full), 32'h1);
    check("d3_e2_full",  32'(full), 32'h0);
    tick();
    check("d3_e3_full",  32'(full), 32'h1);

    // 3. d=4: full drops after exactly 2 edges, almost_full stays
    rp0 = 8'h10;
    tick();
    check("d4_e1_full",  32'(full), 32'h1);
    tick();
    check("d4_e2_full",  32'(full), 32'h0);
    check("d4_e2_afull", 32'(almost_full), 32'h1);
    rp0 = 8'h40;   // d=6
    tick();
    check("d6_e1_afull", 32'(almost_full), 32'h1);
    tick();
    check("d6_e2_afull", 32'(almost_full), 32'h0);

    // 2b/5. d=3 with valid held: full after 2 edges, then overflow
    rp0 = 8'h08;
    valid = 2'b01;
    tick();
    check("v_e1_full", 32'(full), 32'h0);
    tick();
    check("v_e2_full", 32'(full), 32'h1);
    check("v_e2_ovf",  32'(overflow), 32'h0);
    tick();
    check("v_e3_ovf",  32'(overflow), 32'h1);
    tick();
    check("ovf_sticky", 32'(overflow), 32'h1);
    clear_errors = 1'b1;
    tick();
    check("ovf_set_wins", 32'(overflow), 32'h1);
    valid = 2'b00;
    tick();
    check("ovf_cleared", 32'(overflow), 32'h0);
    check("full_idle_hold", 32'(full), 32'h1);
    clear_errors = 1'b0;

    // 4. wrap: ch1 wp=0x80, rp=0x01 -> d=1
    wp1 = 8'h80;
    rp1 = 8'h01;
    repeat (3) tick();
    check("wrap_full",  32'(full), 32'h3);
    check("wrap_afull", 32'(almost_full), 32'h3);
    check("wrap_ovf",   32'(overflow), 32'h0);

    // 6. ch1 write pointer with two hot bits
    wp1 = 8'h03;
    tick();
    check("perr_set", 32'(pointer_error), 32'h2);
    wp1 = 8'h80;
    tick();
    check("perr_sticky", 32'(pointer_error), 32'h2);
    // zero-hot pointer on ch0
    wp0 = 8'h00;
    tick();
    check("perr_zero", 32'(pointer_error), 32'h3);
    wp0 = 8'h01;
    clear_errors = 1'b1;
    tick();
    check("perr_cleared", 32'(pointer_error), 32'h0);
    clear_errors = 1'b0;
    wp1 = 8'h03;
    tick();
    check("perr_reset_pre", 32'(pointer_error), 32'h2);
    wp1 = 8'h80;

    // asynchronous reset away from any edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_full",  32'(full), 32'h0);
    check("arst_afull", 32'(almost_full), 32'h0);
    check("arst_perr",  32'(pointer_error), 32'h0);
    check("arst_ovf",   32'(overflow), 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rebuild_full", 32'(full), 32'h3);
    check("rebuild_perr", 32'(pointer_error), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
